// File: rtl/dbus_pkg.sv
// -----------------------------------------------------------------------------
// dbus_pkg
// Shared types and constants for the data-bus arbiter slice.
//   owner_t             : bus owner of a cycle (nobody, CPU m0, DMA m1)
//   RAMADDRBASE_DEFAULT : first address routed to memory; below it is IO space
//   MAXWAIT_DEFAULT     : denied m1 cycles tolerated before m1 is forced in
//   WCNT_MAX            : saturation value of the 8-bit wait counter
// -----------------------------------------------------------------------------
package dbus_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  localparam logic [15:0] RAMADDRBASE_DEFAULT = 16'h2000;
  localparam int          MAXWAIT_DEFAULT     = 8;
  localparam logic [7:0]  WCNT_MAX            = 8'hFF;

endpackage

// File: rtl/dbus_region_steer.sv
// -----------------------------------------------------------------------------
// dbus_region_steer
// Splits the shared bus between the memory and IO regions.
//   clk, reset      : system clock, asynchronous active-high reset
//   dread_addr      : muxed read address of the granted access
//   dwrite_addr     : muxed write address of the granted access
//   dwrite_en       : muxed byte write enables (2'b00 when nobody is granted)
//   mem_dread_data  : memory read data, one cycle after the address
//   io_dread_data   : iosystem read data, one cycle after the address
//   mem_dwrite_en   : write enables gated to the memory region
//   io_dwrite_en    : write enables gated to the IO region
//   dread_data      : read data of last cycle's access, taken from its region
// -----------------------------------------------------------------------------
module dbus_region_steer
  import dbus_pkg::*;
#(
  parameter logic [15:0] RAMADDRBASE = RAMADDRBASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dread_addr,
  input  logic [15:0] dwrite_addr,
  input  logic [1:0]  dwrite_en,
  input  logic [15:0] mem_dread_data,
  input  logic [15:0] io_dread_data,
  output logic [1:0]  mem_dwrite_en,
  output logic [1:0]  io_dwrite_en,
  output logic [15:0] dread_data
);

  logic rsel;
  logic write_is_mem;

  // Only one region ever sees the write enables; the other is held at zero.
  assign write_is_mem  = (dwrite_addr >= RAMADDRBASE);
  assign mem_dwrite_en = write_is_mem ? dwrite_en : 2'b00;
  assign io_dwrite_en  = write_is_mem ? 2'b00 : dwrite_en;

  // Slaves answer one cycle late, so remember which region this cycle's read
  // address pointed at and pick that slave's data on the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsel <= 1'b0;
    end else begin
      rsel <= (dread_addr >= RAMADDRBASE);
    end
  end

  assign dread_data = rsel ? mem_dread_data : io_dread_data;

endmodule

// File: rtl/dbus_arbiter.sv
// -----------------------------------------------------------------------------
// dbus_arbiter
// Shares the 16-bit data bus between the CPU (m0) and a DMA master (m1).
// m0 normally wins; m1 is forced in after MAXWAIT consecutive denied cycles;
// a master that owns the bus and asserts lock keeps it (atomic RMW).
//   clk, reset                    : system clock, async active-high reset
//   mN_req / mN_lock              : request, keep-ownership hint
//   mN_dread_addr / mN_dwrite_*   : master read address, write addr/data/enables
//   mN_gnt                        : combinational grant for this cycle
//   mN_dread_data / mN_rvalid     : read return for last cycle's granted access
//   dread_addr / dwrite_addr / dwrite_data : muxed bus to the slaves
//   mem_dwrite_en / io_dwrite_en  : region-gated write enables
//   mem_dread_data / io_dread_data: slave read data (1-cycle latency)
// -----------------------------------------------------------------------------
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter logic [15:0] RAMADDRBASE = RAMADDRBASE_DEFAULT,
  parameter int          MAXWAIT     = MAXWAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [15:0] m0_dread_addr,
  input  logic [15:0] m0_dwrite_addr,
  input  logic [15:0] m0_dwrite_data,
  input  logic [1:0]  m0_dwrite_en,
  output logic        m0_gnt,
  output logic [15:0] m0_dread_data,
  output logic        m0_rvalid,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [15:0] m1_dread_addr,
  input  logic [15:0] m1_dwrite_addr,
  input  logic [15:0] m1_dwrite_data,
  input  logic [1:0]  m1_dwrite_en,
  output logic        m1_gnt,
  output logic [15:0] m1_dread_data,
  output logic        m1_rvalid,
  output logic [15:0] dread_addr,
  output logic [15:0] dwrite_addr,
  output logic [15:0] dwrite_data,
  output logic [1:0]  mem_dwrite_en,
  output logic [1:0]  io_dwrite_en,
  input  logic [15:0] mem_dread_data,
  input  logic [15:0] io_dread_data
);

  localparam logic [7:0] MAXWAIT_W = 8'(MAXWAIT);

  owner_t      owner;
  owner_t      rown;
  owner_t      grant;
  logic [7:0]  wcnt;
  logic [1:0]  dwrite_en;
  logic [15:0] dread_data;

  // Priority: an owning master with lock keeps the bus (so an m0 RMW stays
  // atomic even when m1 is starved), then a starved m1, then m0, then m1.
  // Grant is forced off while reset is high so nothing reaches the slaves.
  always_comb begin
    grant = OWN_IDLE;
    if (reset) begin
      grant = OWN_IDLE;
    end else if (owner == OWN_M0 && m0_lock && m0_req) begin
      grant = OWN_M0;
    end else if (owner == OWN_M1 && m1_lock && m1_req) begin
      grant = OWN_M1;
    end else if (m1_req && wcnt >= MAXWAIT_W) begin
      grant = OWN_M1;
    end else if (m0_req) begin
      grant = OWN_M0;
    end else if (m1_req) begin
      grant = OWN_M1;
    end
  end

  assign m0_gnt = (grant == OWN_M0);
  assign m1_gnt = (grant == OWN_M1);

  // Owner and read-return owner both follow the grant; the wait counter only
  // accumulates while m1 is actually asking and being refused, and sticks at
  // its maximum rather than wrapping back under MAXWAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner <= OWN_IDLE;
      rown  <= OWN_IDLE;
      wcnt  <= 8'd0;
    end else begin
      owner <= grant;
      rown  <= grant;
      if (!m1_req || grant == OWN_M1) begin
        wcnt <= 8'd0;
      end else if (wcnt != WCNT_MAX) begin
        wcnt <= wcnt + 8'd1;
      end
    end
  end

  // Slave-side bus follows the granted master; an idle bus is driven to zero.
  always_comb begin
    dread_addr  = 16'h0000;
    dwrite_addr = 16'h0000;
    dwrite_data = 16'h0000;
    dwrite_en   = 2'b00;
    case (grant)
      OWN_M0: begin
        dread_addr  = m0_dread_addr;
        dwrite_addr = m0_dwrite_addr;
        dwrite_data = m0_dwrite_data;
        dwrite_en   = m0_dwrite_en;
      end
      OWN_M1: begin
        dread_addr  = m1_dread_addr;
        dwrite_addr = m1_dwrite_addr;
        dwrite_data = m1_dwrite_data;
        dwrite_en   = m1_dwrite_en;
      end
      default: begin
        dread_addr  = 16'h0000;
        dwrite_addr = 16'h0000;
        dwrite_data = 16'h0000;
        dwrite_en   = 2'b00;
      end
    endcase
  end

  dbus_region_steer #(
    .RAMADDRBASE(RAMADDRBASE)
  ) u_region_steer (
    .clk           (clk),
    .reset         (reset),
    .dread_addr    (dread_addr),
    .dwrite_addr   (dwrite_addr),
    .dwrite_en     (dwrite_en),
    .mem_dread_data(mem_dread_data),
    .io_dread_data (io_dread_data),
    .mem_dwrite_en (mem_dwrite_en),
    .io_dwrite_en  (io_dwrite_en),
    .dread_data    (dread_data)
  );

  // Both masters see the same returned data; rvalid says whose access it was,
  // which is last cycle's owner and not necessarily the current grant.
  assign m0_dread_data = dread_data;
  assign m1_dread_data = dread_data;
  assign m0_rvalid     = (rown == OWN_M0);
  assign m1_rvalid     = (rown == OWN_M1);

endmodule

// File: tb/tb_dbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dbus_arbiter
// Directed scenarios plus a random phase for dbus_arbiter, compared each cycle
// against a behavioural model of the arbitration and read-return rules.
// -----------------------------------------------------------------------------
module tb_dbus_arbiter;

  localparam logic [15:0] BASE = 16'h2000;
  localparam int          MAXW = 8;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_lock, m1_req, m1_lock;
  logic [15:0] m0_dread_addr, m0_dwrite_addr, m0_dwrite_data;
  logic [15:0] m1_dread_addr, m1_dwrite_addr, m1_dwrite_data;
  logic [1:0]  m0_dwrite_en, m1_dwrite_en;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [15:0] m0_dread_data, m1_dread_data;
  logic [15:0] dread_addr, dwrite_addr, dwrite_data;
  logic [1:0]  mem_dwrite_en, io_dwrite_en;
  logic [15:0] mem_dread_data, io_dread_data;

  int checks = 0;
  int errors = 0;

  // Model state: who held the bus last cycle (0 none, 1 m0, 2 m1), how many
  // cycles in a row m1 has been refused, and where last cycle's read went.
  int m_owner;
  int m_wait;
  int m_rown;
  bit m_rsel_mem;

  dbus_arbiter #(
    .RAMADDRBASE(BASE),
    .MAXWAIT    (MAXW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .m0_req        (m0_req),
    .m0_lock       (m0_lock),
    .m0_dread_addr (m0_dread_addr),
    .m0_dwrite_addr(m0_dwrite_addr),
    .m0_dwrite_data(m0_dwrite_data),
    .m0_dwrite_en  (m0_dwrite_en),
    .m0_gnt        (m0_gnt),
    .m0_dread_data (m0_dread_data),
    .m0_rvalid     (m0_rvalid),
    .m1_req        (m1_req),
    .m1_lock       (m1_lock),
    .m1_dread_addr (m1_dread_addr),
    .m1_dwrite_addr(m1_dwrite_addr),
    .m1_dwrite_data(m1_dwrite_data),
    .m1_dwrite_en  (m1_dwrite_en),
    .m1_gnt        (m1_gnt),
    .m1_dread_data (m1_dread_data),
    .m1_rvalid     (m1_rvalid),
    .dread_addr    (dread_addr),
    .dwrite_addr   (dwrite_addr),
    .dwrite_data   (dwrite_data),
    .mem_dwrite_en (mem_dwrite_en),
    .io_dwrite_en  (io_dwrite_en),
    .mem_dread_data(mem_dread_data),
    .io_dread_data (io_dread_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] randAddr();
    case ($urandom_range(0, 3))
      0: return 16'($urandom_range(0, 32'h1FFF));
      1: return 16'($urandom_range(32'h2000, 32'hFFFF));
      2: return BASE;
      default: return BASE - 16'd1;
    endcase
  endfunction

  // Sets request/lock bits; everything else gets fresh random values that
  // directed steps may override afterwards.
  task automatic applyStimulus(input logic r0, input logic l0, input logic r1, input logic l1);
    m0_req         = r0;
    m0_lock        = l0;
    m1_req         = r1;
    m1_lock        = l1;
    m0_dread_addr  = randAddr();
    m0_dwrite_addr = randAddr();
    m0_dwrite_data = 16'($urandom);
    m0_dwrite_en   = 2'($urandom);
    m1_dread_addr  = randAddr();
    m1_dwrite_addr = randAddr();
    m1_dwrite_data = 16'($urandom);
    m1_dwrite_en   = 2'($urandom);
    mem_dread_data = 16'($urandom);
    io_dread_data  = 16'($urandom);
  endtask

  task automatic modelReset();
    m_owner    = 0;
    m_wait     = 0;
    m_rown     = 0;
    m_rsel_mem = 1'b0;
  endtask

  function automatic int expGrant();
    if (reset) return 0;
    if (m_owner == 1 && m0_lock && m0_req) return 1;
    if (m_owner == 2 && m1_lock && m1_req) return 2;
    if (m1_req && m_wait >= MAXW) return 2;
    if (m0_req) return 1;
    if (m1_req) return 2;
    return 0;
  endfunction

  // Compare every observable output of the current cycle with the model.
  task automatic checkOutput();
    int g;
    logic [15:0] ra, wa, wd, rd;
    logic [1:0]  en;
    g  = expGrant();
    ra = (g == 1) ? m0_dread_addr  : (g == 2) ? m1_dread_addr  : 16'h0;
    wa = (g == 1) ? m0_dwrite_addr : (g == 2) ? m1_dwrite_addr : 16'h0;
    wd = (g == 1) ? m0_dwrite_data : (g == 2) ? m1_dwrite_data : 16'h0;
    en = (g == 1) ? m0_dwrite_en   : (g == 2) ? m1_dwrite_en   : 2'b00;
    rd = m_rsel_mem ? mem_dread_data : io_dread_data;
    checkVal("m0_gnt", 32'(m0_gnt), 32'(g == 1));
    checkVal("m1_gnt", 32'(m1_gnt), 32'(g == 2));
    checkVal("dread_addr", 32'(dread_addr), 32'(ra));
    checkVal("dwrite_addr", 32'(dwrite_addr), 32'(wa));
    checkVal("dwrite_data", 32'(dwrite_data), 32'(wd));
    checkVal("mem_dwrite_en", 32'(mem_dwrite_en), (wa >= BASE) ? 32'(en) : 32'd0);
    checkVal("io_dwrite_en", 32'(io_dwrite_en), (wa < BASE) ? 32'(en) : 32'd0);
    checkVal("m0_rvalid", 32'(m0_rvalid), 32'(m_rown == 1));
    checkVal("m1_rvalid", 32'(m1_rvalid), 32'(m_rown == 2));
    checkVal("m0_dread_data", 32'(m0_dread_data), 32'(rd));
    checkVal("m1_dread_data", 32'(m1_dread_data), 32'(rd));
    checkVal("wcnt", 32'(dut.wcnt), 32'(m_wait));
  endtask

  task automatic advance();
    int g;
    logic [15:0] ra;
    @(posedge clk);
    if (reset) begin
      modelReset();
    end else begin
      g  = expGrant();
      ra = (g == 1) ? m0_dread_addr : (g == 2) ? m1_dread_addr : 16'h0;
      m_wait     = (!m1_req || g == 2) ? 0 : ((m_wait + 1 > 255) ? 255 : m_wait + 1);
      m_owner    = g;
      m_rown     = g;
      m_rsel_mem = (ra >= BASE);
    end
    #1;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkOutput();
    advance();
  endtask

  initial begin
    int m1_count;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    modelReset();

    // Reset state
    repeat (2) begin
      @(negedge clk);
      checkOutput();
      checkVal("rst_m0_gnt", 32'(m0_gnt), 32'd0);
      checkVal("rst_mem_en", 32'(mem_dwrite_en), 32'd0);
      advance();
    end
    reset = 1'b0;

    // Scenario 1: single m0 write into memory space
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    m0_dwrite_addr = 16'h2004;
    m0_dwrite_en   = 2'b11;
    @(negedge clk);
    checkOutput();
    checkVal("t1_m0_gnt", 32'(m0_gnt), 32'd1);
    checkVal("t1_mem_en", 32'(mem_dwrite_en), 32'd3);
    checkVal("t1_io_en", 32'(io_dwrite_en), 32'd0);
    advance();

    // Idle bus: nothing granted, no enables, rvalid gone after one cycle
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    @(negedge clk);
    checkOutput();
    checkVal("idle_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
    checkVal("idle_en", 32'({mem_dwrite_en, io_dwrite_en}), 32'd0);
    checkVal("idle_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
    advance();

    // Scenario 2: both request continuously; m1 gets every ninth cycle
    m1_count = 0;
    for (int i = 0; i < 27; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput();
      checkVal($sformatf("t2_m1_gnt_%0d", i), 32'(m1_gnt), 32'((i % 9) == 8));
      if (m1_gnt) m1_count++;
      advance();
    end
    checkVal("t2_m1_count", 32'(m1_count), 32'd3);

    // Scenario 3: back-to-back reads by different masters in different regions
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    m0_dread_addr = 16'h0010;
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    m1_dread_addr  = 16'h2000;
    io_dread_data  = 16'hA5A5;
    mem_dread_data = 16'h5A5A;
    @(negedge clk);
    checkOutput();
    checkVal("t3_m0_rvalid", 32'(m0_rvalid), 32'd1);
    checkVal("t3_m0_data", 32'(m0_dread_data), 32'hA5A5);
    advance();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    io_dread_data  = 16'h1111;
    mem_dread_data = 16'hBEEF;
    @(negedge clk);
    checkOutput();
    checkVal("t3_m1_rvalid", 32'(m1_rvalid), 32'd1);
    checkVal("t3_m0_rvalid_off", 32'(m0_rvalid), 32'd0);
    checkVal("t3_m1_data", 32'(m1_dread_data), 32'hBEEF);
    advance();

    // Scenario 4: m1 locks for three cycles while m0 keeps requesting
    m1_count = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus((i != 0), 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput();
      if (m1_gnt) m1_count++;
      advance();
    end
    checkVal("t4_m1_lock_cycles", 32'(m1_count), 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput();
    checkVal("t4_m0_after_unlock", 32'(m0_gnt), 32'd1);
    advance();

    // Scenario 5: reset in the middle of a granted access
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    m0_dread_addr  = 16'h2100;
    m0_dwrite_addr = 16'h2100;
    m0_dwrite_en   = 2'b01;
    stepCycle();
    #1;
    checkVal("t5_pre_rvalid", 32'(m0_rvalid), 32'd1);
    checkVal("t5_pre_gnt", 32'(m0_gnt), 32'd1);
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput();
    checkVal("t5_gnt", 32'(m0_gnt), 32'd0);
    checkVal("t5_rvalid", 32'(m0_rvalid), 32'd0);
    checkVal("t5_mem_en", 32'(mem_dwrite_en), 32'd0);
    stepCycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput();
    checkVal("t5_no_stale_rvalid", 32'(m0_rvalid), 32'd0);
    advance();

    // Scenario 6: m0 locked for 300 cycles starves m1 up to saturation
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      stepCycle();
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput();
    checkVal("t6_wcnt_sat", 32'(dut.wcnt), 32'd255);
    checkVal("t6_lock_holds", 32'(m0_gnt), 32'd1);
    advance();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput();
    checkVal("t6_m1_forced", 32'(m1_gnt), 32'd1);
    advance();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom), ($urandom_range(0, 3) != 0),
                    1'($urandom), ($urandom_range(0, 3) == 0));
      stepCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
